// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter (8N1) with a small TX FIFO, intended to sit
//   on a core's data-memory store interface. The block decodes a 16-byte
//   window at BASE_ADDR:
//     +0x0 DATA   : write pushes wd[7:0] into the FIFO; reads 0
//     +0x4 STATUS : {28'b0, overflow, fifo_empty, fifo_full, busy};
//                   any write clears the sticky overflow flag
//     +0x8 DIV    : bit period in clk cycles (16 bits, 0 is stored as 1)
//     +0xC        : reserved, reads 0, writes ignored
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   we    : store strobe
//   addr  : byte address
//   wd    : store data
//   rd    : combinational read data (0 when sel is low)
//   sel   : addr lies inside this block's window
//   tx    : registered UART serial output, idle high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Control state
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  // Datapath state (not reset)
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  // Decode
  logic [1:0]    reg_off;
  logic          wr_data, wr_status, wr_div;
  logic          fifo_empty, fifo_full;
  logic          push, pop, ovf_set;
  logic [7:0]    fifo_head;
  logic          busy;

  // Address bits below the word offset and the upper store data are unused.
  logic          unused_ok;
  assign unused_ok = ^{addr[1:0], wd[31:16]};

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = addr[3:2];
  assign wr_data   = we && sel && (reg_off == 2'd0);
  assign wr_status = we && sel && (reg_off == 2'd1);
  assign wr_div    = we && sel && (reg_off == 2'd2);

  // The extra pointer MSB tells full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO still lands if the transmitter pops this cycle.
  assign push    = wr_data && (!fifo_full || pop);
  assign ovf_set = wr_data && fifo_full && !pop;

  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;

  // Register read mux
  always_comb begin
    rd = 32'h0;
    if (sel) begin
      case (reg_off)
        2'd1:    rd = {28'h0, ovf_q, fifo_empty, fifo_full, busy};
        2'd2:    rd = {16'h0, div_q};
        default: rd = 32'h0;
      endcase
    end
  end

  // Register-file next state
  always_comb begin
    // Sticky overflow: a set in the same cycle as a clear wins.
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr_status) begin
      ovf_d = 1'b0;
    end

    div_d = div_q;
    if (wr_div) begin
      div_d = (wd[15:0] == 16'h0) ? 16'd1 : wd[15:0];
    end

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Transmit FSM next state. Every bit reloads the counter from div_q, so a
  // DIV write only takes effect at the next bit boundary.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = div_q - 16'd1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (cnt_q == 16'h0) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          cnt_d     = div_q - 16'd1;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == 16'h0) begin
          cnt_d     = div_q - 16'd1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift right so the next data bit is always at shift_q[0].
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == 16'h0) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame, no idle gap.
            pop     = 1'b1;
            shift_d = fifo_head;
            cnt_d   = div_q - 16'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'h0;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'h0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      div_q     <= DIV_RESET;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Datapath registers: contents are don't-care until qualified by control.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wd[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Store: captured at the next rising edge, returns 1 ns after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    addr = a;
    #1;
    v = rd;
    chk(tag, v, exp);
  endtask

  initial begin
    logic [9:0] fr;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wd    = 32'h0;

    // Reset state
    #12;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk_reg("rst_status", A_STAT, 32'h4);
    rst_n = 1'b1;
    chk("rst_sel", {31'h0, sel}, 32'h1);
    tick(2);
    chk_reg("rst_div", A_DIV, 32'd234);
    chk("rst_tx_idle", {31'h0, tx}, 32'h1);

    // 0xA5 with div=4: 40-cycle frame starting 1 cycle after the write
    wr(A_DIV, 32'd4);
    chk_reg("div4", A_DIV, 32'd4);
    wr(A_DATA, 32'hA5);
    chk("a5_pre_tx", {31'h0, tx}, 32'h1);
    chk_reg("a5_pre_status", A_STAT, 32'h0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("a5_tx", {31'h0, tx}, {31'h0, fr[i/4]});
      chk_reg("a5_busy", A_STAT, 32'h5);
    end
    tick(1);
    chk("a5_end_tx", {31'h0, tx}, 32'h1);
    chk_reg("a5_end_status", A_STAT, 32'h4);

    // DIV=0 stores 1; DIV=8 mid start bit affects only the next bit
    wr(A_DIV, 32'h0);
    chk_reg("div0", A_DIV, 32'd1);
    wr(A_DIV, 32'd4);
    wr(A_DATA, 32'h55);              // edge N
    tick(1);                         // N+1
    chk("d8_start", {31'h0, tx}, 32'h0);
    tick(1);                         // N+2
    wr(A_DIV, 32'd8);                // N+3
    chk_reg("d8_div", A_DIV, 32'd8);
    tick(1);                         // N+4
    chk("d8_start_end", {31'h0, tx}, 32'h0);
    tick(1);                         // N+5
    chk("d8_bit0_first", {31'h0, tx}, 32'h1);
    wr(A_DATA, 32'h33);              // N+6, queued behind the frame
    chk("d8_bit0_n6", {31'h0, tx}, 32'h1);
    chk_reg("d8_status_queued", A_STAT, 32'h1);
    tick(6);                         // N+12
    chk("d8_bit0_last", {31'h0, tx}, 32'h1);
    tick(1);                         // N+13
    chk("d8_bit1", {31'h0, tx}, 32'h0);

    // Asynchronous reset in the middle of a data bit
    rst_n = 1'b0;
    #1;
    chk("arst_tx", {31'h0, tx}, 32'h1);
    chk_reg("arst_status", A_STAT, 32'h4);
    chk_reg("arst_div", A_DIV, 32'd234);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("arst_rel_tx1", {31'h0, tx}, 32'h1);
    tick(3);
    chk("arst_rel_tx4", {31'h0, tx}, 32'h1);
    chk_reg("arst_rel_status", A_STAT, 32'h4);

    // div=2, five back-to-back writes into a depth-4 FIFO, then two overflows
    wr(A_DIV, 32'd2);
    wr(A_DATA, 32'h11);              // edge N
    wr(A_DATA, 32'h22);              // N+1 (first byte popped here)
    wr(A_DATA, 32'h33);
    wr(A_DATA, 32'h44);
    wr(A_DATA, 32'h55);              // N+4
    chk_reg("b2b_full", A_STAT, 32'h3);
    wr(A_DATA, 32'h66);              // N+5, dropped
    chk_reg("b2b_ovf6", A_STAT, 32'hB);
    wr(A_DATA, 32'h77);              // N+6, dropped
    chk_reg("b2b_ovf7", A_STAT, 32'hB);
    for (int c = 7; c <= 101; c++) begin
      tick(1);
      if (c == 101) begin
        chk("b2b_idle_tx", {31'h0, tx}, 32'h1);
        chk_reg("b2b_idle_status", A_STAT, 32'hC);
      end else if (c % 20 == 0) begin
        chk("b2b_stop_tx", {31'h0, tx}, 32'h1);
      end else if (c % 20 == 1) begin
        chk("b2b_start_tx", {31'h0, tx}, 32'h0);
        if (c == 21) chk_reg("b2b_pop_status", A_STAT, 32'h9);
      end else if (c == 23) begin
        // 0x22 bit0 = 0 held for cycles 23..24
        chk("b2b_f2_bit0", {31'h0, tx}, 32'h0);
      end else if (c == 25) begin
        // 0x22 bit1 = 1
        chk("b2b_f2_bit1", {31'h0, tx}, 32'h1);
      end
    end

    // STATUS write clears overflow regardless of data
    wr(A_STAT, 32'hFFFF_FFFF);
    chk_reg("ovf_clear", A_STAT, 32'h4);

    // Outside the window and reserved offset
    addr = BASE + 32'h10;
    #1;
    chk("win_sel_hi", {31'h0, sel}, 32'h0);
    chk("win_rd_hi", rd, 32'h0);
    addr = BASE - 32'h4;
    #1;
    chk("win_sel_lo", {31'h0, sel}, 32'h0);
    wr(BASE + 32'h10, 32'h5A);
    wr(BASE + 32'h18, 32'h7);
    tick(1);
    chk("win_tx", {31'h0, tx}, 32'h1);
    chk_reg("win_status", A_STAT, 32'h4);
    chk_reg("win_div", A_DIV, 32'd2);
    addr = A_RSV;
    #1;
    chk("rsv_sel", {31'h0, sel}, 32'h1);
    chk("rsv_rd", rd, 32'h0);
    wr(A_RSV, 32'hFF);
    chk_reg("rsv_div", A_DIV, 32'd2);
    chk_reg("rsv_status", A_STAT, 32'h4);
    chk_reg("data_rd", A_DATA, 32'h0);
    tick(1);
    chk("rsv_tx", {31'h0, tx}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, the peripheral base address; the block decodes a 16-byte window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the TX FIFO depth in bytes; it is a power of two and at least 2.
REQ-003 SHALL have parameter DIV_RESET, default 16'd234, the reset bit period in clk cycles (27 MHz / 115200).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port we, input, 1 bit: store strobe from the core data-memory interface.
REQ-007 SHALL have port addr, input, 32 bits: byte address from the core data-memory interface.
REQ-008 SHALL have port wd, input, 32 bits: store data.
REQ-009 SHALL have port rd, output, 32 bits: combinational read data.
REQ-010 SHALL have port sel, output, 1 bit: high when addr lies in the window, so the top level can mux rd against dmem.
REQ-011 SHALL have port tx, output, 1 bit: UART serial line, idle high.

Function
REQ-012 SHALL decode sel = (addr[31:4] == BASE_ADDR[31:4]), with register offset addr[3:2].
- 0 = DATA
- 1 = STATUS
- 2 = DIV
- 3 = reserved
REQ-013 SHALL, on we && sel && DATA while the FIFO is not full, push wd[7:0] into the FIFO at that clock edge.
REQ-014 SHALL, on a DATA write while the FIFO is full, drop the byte and set sticky overflow.
REQ-015 SHALL treat a DATA write in the same cycle as a FIFO pop as accepted when the FIFO is full; the count is unchanged.
REQ-016 SHALL clear overflow on any write to STATUS, regardless of data; if clear and set occur in the same cycle, set wins.
REQ-017 SHALL load div <= wd[15:0] on a DIV write; a value of 0 is stored as 1.
REQ-018 SHALL sample a new div only at the start of each bit; a bit in progress keeps its period.
REQ-019 SHALL drive rd combinationally:
- DATA reads 0.
- STATUS reads {28'b0, overflow, fifo_empty, fifo_full, busy}.
- DIV reads {16'b0, div}.
- Reserved offset, or sel low, reads 0.
REQ-020 SHALL ignore writes to the reserved offset and writes with sel low.
REQ-021 SHALL implement the FSM states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-022 SHALL make the IDLE -> START transition when the FIFO is not empty: pop the head into the shift register and load the bit counter with div-1.
REQ-023 SHALL hold each bit for exactly div cycles: the counter decrements each cycle and the bit ends when it reaches 0.
REQ-024 SHALL follow START (tx=0) with DATA: 8 bits LSB first, using a 3-bit index that wraps from 7 and exits to STOP.
REQ-025 SHALL follow DATA with STOP (tx=1); after STOP the FSM goes to START directly if the FIFO is not empty, else to IDLE.
REQ-026 SHALL transmit back-to-back frames with no extra idle cycles; each frame is exactly 10*div cycles.
REQ-027 SHALL have latency such that a DATA write at edge N into an empty, idle block drives tx low after edge N+1.
REQ-028 SHALL register tx as a flop output, glitch-free.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force the following, regardless of any frame in progress:
- state IDLE
- tx=1
- FIFO empty
- overflow=0
- div=DIV_RESET
- counters 0
REQ-031 SHALL resume on rst_n deassertion with the first rising edge, with no spurious start bit.

Verification
REQ-032 SHALL cover: with div=4, write 0xA5 to DATA.
- tx is low for 4 cycles starting 1 cycle after the write.
- Bits 1,0,1,0,0,1,0,1 follow, 4 cycles each.
- Stop is high for 4 cycles; the frame totals 40 cycles.
- busy is 1 throughout, then STATUS reads 0x4.
REQ-033 SHALL cover: with div=2, write 5 bytes in consecutive cycles (FIFO_DEPTH=4).
- The first byte is popped after 1 cycle, so all 5 are accepted and overflow=0.
- A 6th and 7th write give full=1 and then overflow=1.
- The frames are back-to-back with 20-cycle spacing.
REQ-034 SHALL cover: write to STATUS while overflow=1 -> overflow=0 on the next read; a write to STATUS and an overflowing DATA write cannot occur in the same cycle (single port), so check only the sequential clear.
REQ-035 SHALL cover: write DIV=0 -> DIV reads 1; write DIV=8 mid-bit -> the current bit keeps the old period and the next bit lasts 8 cycles.
REQ-036 SHALL cover: assert rst_n low mid-data-bit -> tx=1 immediately (asynchronously), STATUS=0x4, DIV=234; after release, tx stays high with no FIFO content.
REQ-037 SHALL cover: addr=BASE_ADDR+0x10 or BASE_ADDR+0xC -> sel=0 or reserved, rd=0, and no state change on we.
